// File: rtl/jtframe_dump_pkg.sv
// Shared types and constants for the frame tracker / dump window logic.
package jtframe_dump_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_DL,
    ST_COUNT,
    ST_DUMPING,
    ST_DONE
  } dump_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/jtframe_crc16_step.sv
// Combinational CRC-16-CCITT update over one DW-bit word, MSB first.
module jtframe_crc16_step
  import jtframe_dump_pkg::*;
#(
  parameter int unsigned DW = 12
) (
  input  logic [15:0]   crc,
  input  logic [DW-1:0] data,
  output logic [15:0]   crc_next
);

  // Shift every data bit through the LFSR within a single cycle
  always_comb begin
    crc_next = crc;
    for (int unsigned i = 0; i < DW; i++) begin
      crc_next = {crc_next[14:0], 1'b0} ^
                 ({16{crc_next[15] ^ data[DW-1-i]}} & CRC16_POLY);
    end
  end

endmodule

// File: rtl/jtframe_frame_tracker.sv
// Frame counter and dump window generator driven by vertical sync and
// ROM download status. Optional per-frame CRC-16 of the pixel stream is
// enabled by defining JTFRAME_FRAME_CRC_EN.
module jtframe_frame_tracker
  import jtframe_dump_pkg::*;
#(
  parameter bit          WAIT_DL     = 1'b1,
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned DUMP_LEN    = 0,
  parameter int unsigned COLORW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pxl_cen,
  input  logic                  vs,
  input  logic                  de,
  input  logic                  downloading,
  input  logic [3*COLORW-1:0]   rgb,
  output logic [31:0]           frame_cnt,
  output logic                  dump_start,
  output logic                  dump_active,
  output logic                  dump_done,
  output logic [15:0]           frame_crc,
  output logic                  crc_valid
);

  localparam dump_state_t INIT_STATE = WAIT_DL ? ST_WAIT_DL : ST_COUNT;

  dump_state_t state_q, state_d;
  logic        vs_l_q, vs_l_d;
  logic        dl_l_q, dl_l_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] len_q, len_d;
  logic        dump_start_q, dump_start_d;
  logic        dump_active_q, dump_active_d;
  logic        dump_done_q, dump_done_d;
  logic        fe, dlf, dlr;

  assign fe  = vs_l_q & ~vs;
  assign dlf = dl_l_q & ~downloading;
  assign dlr = ~dl_l_q & downloading;

  // Next-state, counters and window flags; a download restart overrides all
  always_comb begin
    vs_l_d        = vs;
    dl_l_d        = downloading;
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    len_d         = len_q;
    dump_start_d  = 1'b0;
    dump_done_d   = 1'b0;
    dump_active_d = dump_active_q;
    if (dlr) begin
      state_d       = INIT_STATE;
      frame_cnt_d   = '0;
      len_d         = '0;
      dump_active_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_DL: begin
          if (dlf) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (fe) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (frame_cnt_q == START_FRAME) begin
              dump_start_d  = 1'b1;
              dump_active_d = 1'b1;
              len_d         = '0;
              state_d       = ST_DUMPING;
            end
          end
        end
        ST_DUMPING: begin
          if (fe) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            len_d       = len_q + 32'd1;
            if ((DUMP_LEN != 0) && (len_q + 32'd1 == DUMP_LEN)) begin
              dump_active_d = 1'b0;
              dump_done_d   = 1'b1;
              state_d       = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (fe) frame_cnt_d = frame_cnt_q + 32'd1;
        end
        default: state_d = INIT_STATE;
      endcase
    end
  end

  // Core state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT_STATE;
      vs_l_q        <= 1'b0;
      dl_l_q        <= 1'b0;
      frame_cnt_q   <= '0;
      len_q         <= '0;
      dump_start_q  <= 1'b0;
      dump_active_q <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_l_q        <= vs_l_d;
      dl_l_q        <= dl_l_d;
      frame_cnt_q   <= frame_cnt_d;
      len_q         <= len_d;
      dump_start_q  <= dump_start_d;
      dump_active_q <= dump_active_d;
      dump_done_q   <= dump_done_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign dump_start  = dump_start_q;
  assign dump_active = dump_active_q;
  assign dump_done   = dump_done_q;

`ifdef JTFRAME_FRAME_CRC_EN
  logic [15:0] crc_acc_q, crc_acc_d, crc_next;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d;
  logic        pxl_take;

  assign pxl_take = pxl_cen & de;

  jtframe_crc16_step #(.DW(3*COLORW)) u_crc_step (
    .crc      (crc_acc_q),
    .data     (rgb),
    .crc_next (crc_next)
  );

  // Accumulate pixels; a pixel taken on the frame edge belongs to the closing frame
  always_comb begin
    crc_acc_d   = crc_acc_q;
    frame_crc_d = frame_crc_q;
    crc_valid_d = 1'b0;
    if (dlr) begin
      crc_acc_d = CRC16_INIT;
    end else if (state_q != ST_WAIT_DL) begin
      if (fe) begin
        frame_crc_d = pxl_take ? crc_next : crc_acc_q;
        crc_valid_d = 1'b1;
        crc_acc_d   = CRC16_INIT;
      end else if (pxl_take) begin
        crc_acc_d = crc_next;
      end
    end
  end

  // CRC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc_q   <= CRC16_INIT;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  logic unused_pxl;
  assign unused_pxl = &{1'b0, pxl_cen, de, rgb};
  assign frame_crc  = '0;
  assign crc_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_frame_tracker.sv
// Directed bench for jtframe_frame_tracker (WAIT_DL=1, START_FRAME=5, DUMP_LEN=3).
module tb_jtframe_frame_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        vs = 1'b0;
  logic        de = 1'b0;
  logic        downloading = 1'b1;
  logic [11:0] rgb = '0;
  logic [31:0] frame_cnt;
  logic        dump_start, dump_active, dump_done;
  logic [15:0] frame_crc;
  logic        crc_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_frame_tracker #(
    .WAIT_DL     (1'b1),
    .START_FRAME (5),
    .DUMP_LEN    (3),
    .COLORW      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pxl_cen     (pxl_cen),
    .vs          (vs),
    .de          (de),
    .downloading (downloading),
    .rgb         (rgb),
    .frame_cnt   (frame_cnt),
    .dump_start  (dump_start),
    .dump_active (dump_active),
    .dump_done   (dump_done),
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
  );

  typedef struct {
    logic        dl;
    logic        fr;
    logic [31:0] cnt;
    logic        s;
    logic        a;
    logic        d;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t v(input int dl, input int fr, input int cnt,
                             input int s, input int a, input int d);
    vec_t r;
    r.dl  = (dl != 0);
    r.fr  = (fr != 0);
    r.cnt = cnt;
    r.s   = (s != 0);
    r.a   = (a != 0);
    r.d   = (d != 0);
    return r;
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 11; b >= 0; b--) begin
      if (r[15] ^ w[b]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] cnt,
                           input logic s, input logic a, input logic d);
    check({tag, " frame_cnt"},   frame_cnt, cnt);
    check({tag, " dump_start"},  32'(dump_start), 32'(s));
    check({tag, " dump_active"}, 32'(dump_active), 32'(a));
    check({tag, " dump_done"},   32'(dump_done), 32'(d));
  endtask

  // Called just after a negedge; returns at the negedge where results are visible
  task automatic step(input logic dl, input logic fr);
    downloading = dl;
    if (fr) begin
      vs = 1'b1;
      @(negedge clk);
      vs = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    step(vecs[i].dl, vecs[i].fr);
    check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].s, vecs[i].a, vecs[i].d);
  endtask

  initial begin
    // WAIT_DL hold, count, dump window, DONE entry
    vecs[0]  = v(1,1,0,0,0,0);
    vecs[1]  = v(1,1,0,0,0,0);
    vecs[2]  = v(1,1,0,0,0,0);
    vecs[3]  = v(0,0,0,0,0,0);
    vecs[4]  = v(0,1,1,0,0,0);
    vecs[5]  = v(0,1,2,0,0,0);
    vecs[6]  = v(0,1,3,0,0,0);
    vecs[7]  = v(0,1,4,0,0,0);
    vecs[8]  = v(0,1,5,0,0,0);
    vecs[9]  = v(0,1,6,1,1,0);
    vecs[10] = v(0,0,6,0,1,0);
    vecs[11] = v(0,1,7,0,1,0);
    vecs[12] = v(0,1,8,0,1,0);
    vecs[13] = v(0,1,9,0,0,1);
    vecs[14] = v(0,0,9,0,0,0);
    // restart, then abort mid-dump at frame 6
    vecs[15] = v(1,0,0,0,0,0);
    vecs[16] = v(0,0,0,0,0,0);
    vecs[17] = v(0,1,1,0,0,0);
    vecs[18] = v(0,1,2,0,0,0);
    vecs[19] = v(0,1,3,0,0,0);
    vecs[20] = v(0,1,4,0,0,0);
    vecs[21] = v(0,1,5,0,0,0);
    vecs[22] = v(0,1,6,1,1,0);
    vecs[23] = v(1,0,0,0,0,0);
    vecs[24] = v(1,0,0,0,0,0);
    vecs[25] = v(0,0,0,0,0,0);
    vecs[26] = v(0,1,1,0,0,0);

    repeat (3) @(negedge clk);
    check_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    check("reset frame_crc", 32'(frame_crc), 32'd0);
    check("reset crc_valid", 32'(crc_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 14; i++) apply_vec(i);

    // DONE is sticky: counting continues, no new window
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1);
      check_out($sformatf("done%0d", k), 32'd10 + 32'(k), 1'b0, 1'b0, 1'b0);
    end

    for (int i = 15; i < NV; i++) apply_vec(i);

    // dlr and fe in the same cycle: restart wins
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    downloading = 1'b1;
    @(negedge clk);
    check_out("dlr_fe", 32'd0, 1'b0, 1'b0, 1'b0);

    // dlf and fe in the same cycle: leave WAIT_DL, frame not counted
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    downloading = 1'b0;
    @(negedge clk);
    check_out("dlf_fe", 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_out("dlf_fe next", 32'd1, 1'b0, 1'b0, 1'b0);

    // Wrap-around of the frame counter
    force dut.frame_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("wrap preset", frame_cnt, 32'hFFFF_FFFE);
    step(1'b0, 1'b1);
    check_out("wrap1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_out("wrap2", 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1);
      check_out($sformatf("postwrap%0d", k), 32'(k), 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    check_out("postwrap start", 32'd6, 1'b1, 1'b1, 1'b0);

    // Frame of 4 black pixels
    pxl_cen = 1'b1;
    de      = 1'b1;
    rgb     = 12'h000;
    repeat (4) @(negedge clk);
    pxl_cen = 1'b0;
    de      = 1'b0;
    step(1'b0, 1'b1);
`ifdef JTFRAME_FRAME_CRC_EN
    begin
      logic [15:0] exp_crc;
      exp_crc = 16'hFFFF;
      for (int k = 0; k < 4; k++) exp_crc = crc_model(exp_crc, 12'h000);
      check("crc black", 32'(frame_crc), 32'(exp_crc));
      check("crc_valid pulse", 32'(crc_valid), 32'd1);
      step(1'b0, 1'b0);
      check("crc_valid drop", 32'(crc_valid), 32'd0);
      check("crc hold", 32'(frame_crc), 32'(exp_crc));
    end
    // A pixel taken in the frame-edge cycle belongs to the closing frame
    vs = 1'b1;
    @(negedge clk);
    vs      = 1'b0;
    pxl_cen = 1'b1;
    de      = 1'b1;
    rgb     = 12'h5A3;
    @(negedge clk);
    pxl_cen = 1'b0;
    de      = 1'b0;
    check("crc edge pixel", 32'(frame_crc), 32'(crc_model(16'hFFFF, 12'h5A3)));
    check("crc edge valid", 32'(crc_valid), 32'd1);
`else
    check("crc off value", 32'(frame_crc), 32'd0);
    check("crc off valid", 32'(crc_valid), 32'd0);
    step(1'b0, 1'b0);
    check("crc off value2", 32'(frame_crc), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
